// File: rtl/reg_bank_serial_reader.sv
// Register bank serial read-out: snapshots NUM_REGS registers on a start
// request and shifts them out MSB first, register 0 first, with each bit
// held for CLK_DIV clock cycles. All outputs are registered.
module reg_bank_serial_reader #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 3,
  parameter int CLK_DIV  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_REGS*DATA_W-1:0]   regs_in,
  output logic                         busy,
  output logic                         frame,
  output logic                         sdo,
  output logic                         bit_strobe,
  output logic                         done
);

  localparam int N     = NUM_REGS * DATA_W;
  localparam int BIT_W = (N > 1) ? $clog2(N) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NXT   = (N > 1) ? N - 2 : 0;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state_q;
  logic [N-1:0]       shadow_q;
  logic [N-1:0]       snap_d;
  logic [BIT_W-1:0]   bit_q;
  logic [DIV_W-1:0]   div_q;
  logic               busy_q;
  logic               frame_q;
  logic               sdo_q;
  logic               strobe_q;
  logic               done_q;

  // Reorder the bank so register 0 sits at the top of the shadow; a plain
  // left shift then emits register 0 first, each register MSB first.
  always_comb begin
    snap_d = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      snap_d[(NUM_REGS-1-k)*DATA_W +: DATA_W] = regs_in[k*DATA_W +: DATA_W];
    end
  end

  // Frame sequencer with registered outputs; sdo is loaded one edge ahead
  // from the bit that the shift is about to expose.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      busy_q   <= 1'b0;
      frame_q  <= 1'b0;
      sdo_q    <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= SHIFT;
            shadow_q <= snap_d;
            bit_q    <= '0;
            div_q    <= '0;
            busy_q   <= 1'b1;
            frame_q  <= 1'b1;
            sdo_q    <= snap_d[N-1];
            strobe_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (bit_q == BIT_LAST) begin
              state_q  <= DONE;
              frame_q  <= 1'b0;
              sdo_q    <= 1'b0;
              strobe_q <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              bit_q    <= bit_q + 1'b1;
              shadow_q <= shadow_q << 1;
              sdo_q    <= shadow_q[NXT];
              strobe_q <= 1'b1;
            end
          end else begin
            div_q    <= div_q + 1'b1;
            strobe_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          frame_q  <= 1'b0;
          sdo_q    <= 1'b0;
          strobe_q <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign frame      = frame_q;
  assign sdo        = sdo_q;
  assign bit_strobe = strobe_q;
  assign done       = done_q;

endmodule

// File: doc/reg_bank_serial_reader.md
# reg_bank_serial_reader

Snapshots a bank of parallel 8-bit registers and shifts the captured contents out as a single framed serial stream, MSB first, at a programmable bit rate. It is the read-out side of the register bank: the bank's registers are written through their next-state inputs, and this block reads their current values out to a debug or telemetry link. A start request captures all registers atomically in one clock edge, so the transmitted frame is always a coherent snapshot.

## Interface
Parameters:
- DATA_W, 8, width of each register.
- NUM_REGS, 3, number of registers in the bank (1..16).
- CLK_DIV, 4, clk cycles per serial bit (>= 1).

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  frame request, sampled only in IDLE.
- regs_in  in  NUM_REGS*DATA_W  register bank contents; register 0 occupies bits [DATA_W-1:0], register k occupies bits [(k+1)*DATA_W-1:k*DATA_W].
- busy  out  1  high from the first frame cycle through the done cycle.
- frame  out  1  high while serial bits are being driven.
- sdo  out  1  serial data; 0 when frame is low.
- bit_strobe  out  1  one-cycle pulse in the first clk cycle of each bit period.
- done  out  1  one-cycle pulse after the last bit period.

## Operation
- Reset values: busy=0, frame=0, sdo=0, bit_strobe=0, done=0. Shadow register, bit counter and divider counter are all 0. State is IDLE.
- States and transitions:
  - IDLE: if start=1 at a clock edge, load the shadow register from regs_in, clear both counters and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: drive the current shadow bit.
    - The divider counts 0..CLK_DIV-1. When it wraps, the bit counter increments.
    - When the divider wraps on bit N-1 (N = NUM_REGS*DATA_W), go to DONE.
  - DONE: lasts one cycle with done=1, busy=1, frame=0, sdo=0, then go to IDLE.
- Bit order:
  - Register 0 first, then 1, 2, and so on.
  - Within each register, MSB first.
  - Bit index i (0..N-1) maps to register i/DATA_W, bit DATA_W-1-(i mod DATA_W).
- The snapshot is taken only on the accepting edge. Changes to regs_in during SHIFT or DONE have no effect on the frame in progress.
- start is ignored in SHIFT and DONE. Requests are not queued.
- bit_strobe=1 exactly when state=SHIFT and divider=0.
- With CLK_DIV=1, bit_strobe stays high for the whole frame.
- Counter widths: bit counter is clog2(N) bits wide and the divider is max(1, clog2(CLK_DIV)) bits wide. Neither counter ever exceeds its terminal value.
- Reset asserted mid-frame immediately forces all outputs to their reset values. The frame is aborted and no done pulse is issued. Operation resumes from IDLE after reset is released.

## Timing
- Let the start accepting edge be E0.
- In the cycle after E0: frame=1, busy=1, bit_strobe=1, and sdo carries bit 0 (MSB of register 0).
- Each bit is held for exactly CLK_DIV cycles, so frame stays high for N*CLK_DIV consecutive cycles.
- done=1 in cycle N*CLK_DIV+1 after E0. busy is high for N*CLK_DIV+1 cycles in total.
- The earliest next accepting edge is the end of the IDLE cycle that follows DONE.
- With start held high continuously, consecutive frames are separated by exactly 2 cycles with frame=0: the DONE cycle and the IDLE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Defaults, regs_in reg0=0xA5, reg1=0x3C, reg2=0xFF, one-cycle start pulse: sdo over 24 bit periods is 10100101 00111100 11111111; each bit lasts 4 cycles; frame is high for 96 cycles; done pulses in cycle 97; 24 bit_strobe pulses.
- Same frame, with regs_in changed to all zeros 10 cycles after start: the transmitted sequence is unchanged (0xA5, 0x3C, 0xFF).
- start pulsed at cycles 5, 50 and 96 after the first accept: all ignored; exactly one done; busy drops after cycle 97.
- reset asserted at cycle 40 of a frame: all outputs are 0 in the same cycle, with no done. After release, a start with reg0=0x01 transmits 00000001 first.
- CLK_DIV=1, start held high, regs 0x80, 0x00, 0x01: bit_strobe is continuous during frame; frame is 24 cycles; 2-cycle frame=0 gap between repeated frames.
- NUM_REGS=1, DATA_W=8, CLK_DIV=3, reg0=0x5A: sdo is 01011010 over 24 cycles, and done follows in the next cycle.
